// File: rtl/prime_uart_pkg.sv
// Shared constants, FSM state types and the nibble-to-ASCII helper for the prime UART printer.
package prime_uart_pkg;

  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  // Message sequencer (top) and per-character line FSM (byte transmitter).
  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_SEND} msg_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A + {4'h0, n} - 8'd10);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit, each DIV clocks wide.
module uart_tx_byte
  import prime_uart_pkg::*;
#(
  parameter int DIV = 139
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int              CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIV - 1);

  tx_state_e        r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_sh;
  logic             r_tx;
  logic             w_tick, w_load;

  assign w_tick = (r_cnt == '0);
  // Busy drops during the last stop-bit cycle so the next byte can start with no gap.
  assign o_busy = (r_state != TX_IDLE) && !((r_state == TX_STOP) && w_tick);
  assign w_load = i_start && !o_busy;
  assign o_tx   = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      TX_IDLE:  if (i_start) w_nxt = TX_START;
      TX_START: if (w_tick) w_nxt = TX_DATA;
      TX_DATA:  if (w_tick && r_bit == 3'd7) w_nxt = TX_STOP;
      TX_STOP:  if (w_tick) w_nxt = i_start ? TX_START : TX_IDLE;
      default:  w_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
      r_tx  <= 1'b1;
    end else if (w_load) begin
      r_sh  <= i_byte;
      r_cnt <= CNT_TOP;
      r_bit <= '0;
      r_tx  <= 1'b0;
    end else if (r_state != TX_IDLE) begin
      if (w_tick) begin
        r_cnt <= CNT_TOP;
        case (r_state)
          TX_START: r_tx <= r_sh[0];
          TX_DATA: begin
            r_tx  <= (r_bit == 3'd7) ? 1'b1 : r_sh[1];
            r_sh  <= r_sh >> 1;
            r_bit <= r_bit + 3'd1;
          end
          default:  r_tx <= 1'b1;
        endcase
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/prime_uart_tx.sv
// Prints each accepted prime as uppercase hex + CR LF over an 8N1 UART.
// Define PRIME_UART_ZERO_SUPPRESS_EN to drop leading zero digits (at least one digit is kept).
module prime_uart_tx
  import prime_uart_pkg::*;
#(
  parameter  int WIDTH_LOG = 4,
  parameter  int CLK_HZ    = 16000000,
  parameter  int BAUD      = 115200,
  localparam int W         = 1 << WIDTH_LOG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [W-1:0] data,
  output logic         ready,
  output logic         tx
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int NDIG  = W / 4;
  localparam int IDX_W = $clog2(NDIG + 3);
  localparam logic [IDX_W-1:0] IDX_CR  = IDX_W'(NDIG);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NDIG + 2);

  if (DIV < 2 || WIDTH_LOG < 2) begin : g_param_chk
    $error("prime_uart_tx: DIV must be >= 2 and W a multiple of 4");
  end

  msg_state_e       r_state, w_nxt;
  logic [W-1:0]     r_shift, w_shift_in;
  logic [IDX_W-1:0] r_idx, w_lz;
  logic [7:0]       w_char;
  logic             w_start, w_accept, w_busy;

`ifdef PRIME_UART_ZERO_SUPPRESS_EN
  // Count leading zero nibbles, never the last one, so 0 still prints "0".
  always_comb begin
    logic seen;
    seen = 1'b0;
    w_lz = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (!seen && data[4*i +: 4] == 4'h0) w_lz = w_lz + 1'b1;
      else seen = 1'b1;
    end
  end
`else
  assign w_lz = '0;
`endif

  assign w_shift_in = data << {w_lz, 2'b00};
  assign ready      = (r_state == M_IDLE);

  always_comb begin
    if (r_idx < IDX_CR)       w_char = nib2ascii(r_shift[W-1 -: 4]);
    else if (r_idx == IDX_CR) w_char = CR;
    else                      w_char = LF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= M_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      M_IDLE: if (valid) begin
        w_accept = 1'b1;
        w_nxt    = M_LOAD;
      end
      M_LOAD: begin
        w_start = 1'b1;
        w_nxt   = M_SEND;
      end
      M_SEND: if (!w_busy) begin
        if (r_idx == IDX_END) w_nxt = M_IDLE;
        else                  w_start = 1'b1;
      end
      default: w_nxt = M_IDLE;
    endcase
  end

  // r_idx is the next character to send; the value register shifts one nibble per digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_in;
      r_idx   <= w_lz;
    end else if (w_start) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx < IDX_CR) r_shift <= r_shift << 4;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_byte (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_byte (w_char),
    .o_busy (w_busy),
    .o_tx   (tx)
  );

endmodule
